// File: rtl/sdram_device_model_if.sv
// sdram_device_model_if: command, address and byte-mask pins from an SDRAM controller.
interface sdram_device_model_if;
  logic [12:0] DRAM_ADDR;
  logic [1:0]  DRAM_BA;
  logic        DRAM_CS_N;
  logic        DRAM_RAS_N;
  logic        DRAM_CAS_N;
  logic        DRAM_WE_N;
  logic        DRAM_CKE;
  logic        DRAM_CLK;
  logic        DRAM_LDQM;
  logic        DRAM_UDQM;
  modport master (
    output DRAM_ADDR, DRAM_BA, DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N,
           DRAM_CKE, DRAM_CLK, DRAM_LDQM, DRAM_UDQM
  );
  modport slave (
    input DRAM_ADDR, DRAM_BA, DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N,
          DRAM_CKE, DRAM_CLK, DRAM_LDQM, DRAM_UDQM
  );
endinterface

// File: rtl/sdram_device_model.sv
// sdram_device_model: cycle-level 16-bit SDR SDRAM responder with a reduced internal array.
module sdram_device_model #(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 6
) (
  input  logic                 iclk,
  input  logic                 ireset_n,
  sdram_device_model_if.slave  bus,
  inout  wire  [15:0]          DRAM_DQ,
  output logic                 omode_set,
  output logic                 ocmd_err,
  output logic [3:0]           obank_open,
  output logic [15:0]          orefresh_cnt
);
  localparam int AW = 2 + ROW_BITS + COL_BITS;
  typedef enum logic [2:0] {
    C_LMR = 3'd0, C_REF = 3'd1, C_PRE = 3'd2, C_ACT = 3'd3,
    C_WR  = 3'd4, C_RD  = 3'd5, C_BT  = 3'd6, C_NOP = 3'd7
  } cmd_t;
  logic [15:0]         mem [2**AW];
  logic [ROW_BITS-1:0] bank_row [4];
  logic [1:0]          bl_code;
  logic                cl3;
  logic                b_act, b_wr, b_ap;
  logic [1:0]          b_bank;
  logic [ROW_BITS-1:0] b_row;
  logic [COL_BITS-1:0] b_col;
  logic [2:0]          b_idx;
  logic                p1_v, p2_v, drv;
  logic [15:0]         p1_d, p2_d, dq_out;
  cmd_t                cmd;
  logic                ok, rw_new, stop;
  logic                cur_v, cur_wr, cur_ap, cur_last;
  logic [1:0]          cur_bank;
  logic [ROW_BITS-1:0] cur_row;
  logic [COL_BITS-1:0] cur_start, cur_col, mask;
  logic [2:0]          cur_idx;
  logic [AW-1:0]       addr;
  logic [15:0]         wdata;
  logic                unused;
  assign unused = ^{bus.DRAM_CLK, bus.DRAM_ADDR};
  assign cmd = (bus.DRAM_CKE && !bus.DRAM_CS_N) ?
               cmd_t'({bus.DRAM_RAS_N, bus.DRAM_CAS_N, bus.DRAM_WE_N}) : C_NOP;
  assign ok = (cmd == C_ACT) ? omode_set && !obank_open[bus.DRAM_BA]
            : (cmd == C_RD || cmd == C_WR) ? omode_set && obank_open[bus.DRAM_BA]
            : (cmd == C_REF) ? omode_set && obank_open == 4'b0
            : (cmd == C_LMR) ? obank_open == 4'b0 && !bus.DRAM_ADDR[2] && bus.DRAM_ADDR[6:5] == 2'b01
            : 1'b1;
  assign rw_new = ok && (cmd == C_RD || cmd == C_WR);
  assign stop = cmd == C_BT || (cmd == C_PRE && (bus.DRAM_ADDR[10] || bus.DRAM_BA == b_bank));
  // The word handled at this edge: word 0 of a new command, or the next word of the running burst.
  assign cur_v = rw_new || (b_act && !stop);
  assign cur_wr = rw_new ? cmd == C_WR : b_wr;
  assign cur_ap = rw_new ? bus.DRAM_ADDR[10] : b_ap;
  assign cur_bank = rw_new ? bus.DRAM_BA : b_bank;
  assign cur_row = rw_new ? bank_row[bus.DRAM_BA] : b_row;
  assign cur_start = rw_new ? bus.DRAM_ADDR[COL_BITS-1:0] : b_col;
  assign cur_idx = rw_new ? 3'd0 : b_idx;
  assign mask = ~({COL_BITS{1'b1}} << bl_code);
  assign cur_col = (cur_start & ~mask) | ((cur_start + COL_BITS'(cur_idx)) & mask);
  assign cur_last = cur_idx == 3'((4'd1 << bl_code) - 4'd1);
  assign addr = {cur_bank, cur_row, cur_col};
  assign wdata = {bus.DRAM_UDQM ? mem[addr][15:8] : DRAM_DQ[15:8],
                  bus.DRAM_LDQM ? mem[addr][7:0]  : DRAM_DQ[7:0]};
  assign DRAM_DQ = drv ? dq_out : 'z;
  always_ff @(posedge iclk)
    if (bus.DRAM_CKE && cur_v && cur_wr) mem[addr] <= wdata;
  always_ff @(posedge iclk or negedge ireset_n)
    if (!ireset_n) begin
      omode_set <= 1'b0;
      ocmd_err <= 1'b0;
      obank_open <= 4'b0;
      orefresh_cnt <= 16'd0;
      bank_row <= '{default: '0};
      bl_code <= 2'd0;
      cl3 <= 1'b0;
      b_act <= 1'b0;
      b_wr <= 1'b0;
      b_ap <= 1'b0;
      b_bank <= 2'd0;
      b_row <= '0;
      b_col <= '0;
      b_idx <= 3'd0;
      p1_v <= 1'b0;
      p1_d <= 16'd0;
      p2_v <= 1'b0;
      p2_d <= 16'd0;
      drv <= 1'b0;
      dq_out <= 16'd0;
    end else begin
      ocmd_err <= !ok;
      if (bus.DRAM_CKE) begin
        if (ok && cmd == C_ACT) begin
          obank_open[bus.DRAM_BA] <= 1'b1;
          bank_row[bus.DRAM_BA] <= bus.DRAM_ADDR[ROW_BITS-1:0];
        end
        if (ok && cmd == C_REF) orefresh_cnt <= orefresh_cnt + 16'd1;
        if (ok && cmd == C_LMR) begin
          omode_set <= 1'b1;
          bl_code <= bus.DRAM_ADDR[1:0];
          cl3 <= bus.DRAM_ADDR[4];
        end
        if (cmd == C_PRE) obank_open <= bus.DRAM_ADDR[10] ? 4'b0 : obank_open & ~(4'b1 << bus.DRAM_BA);
        if (cur_v && cur_last && cur_ap) obank_open[cur_bank] <= 1'b0;
        b_act <= cur_v && !cur_last;
        b_wr <= cur_wr;
        b_ap <= cur_ap;
        b_bank <= cur_bank;
        b_row <= cur_row;
        b_col <= cur_start;
        b_idx <= cur_idx + 3'd1;
        // A WRITE flushes read data still in flight so the bus is free for write data.
        if (rw_new && cmd == C_WR) begin
          p1_v <= 1'b0;
          p2_v <= 1'b0;
          drv <= 1'b0;
        end else begin
          p1_v <= cur_v && !cur_wr;
          p1_d <= mem[addr];
          p2_v <= p1_v;
          p2_d <= p1_d;
          drv <= cl3 ? p2_v : p1_v;
          dq_out <= cl3 ? p2_d : p1_d;
        end
      end
    end
endmodule

// File: tb/tb_sdram_device_model.sv
// tb_sdram_device_model: randomized bursts against an address-arithmetic memory model.
module tb_sdram_device_model;
  localparam logic [2:0] LMR = 3'd0, REF = 3'd1, PRE = 3'd2, ACT = 3'd3, WR = 3'd4, RD = 3'd5, BT = 3'd6;
  localparam logic [15:0] Z = 16'hFFFF;
  logic iclk = 1'b0;
  logic ireset_n = 1'b0;
  logic omode_set, ocmd_err;
  logic [3:0] obank_open;
  logic [15:0] orefresh_cnt;
  tri1 [15:0] dq;
  logic tb_oe = 1'b0;
  logic [15:0] tb_dq = 16'd0;
  int errs = 0, checks = 0;
  logic [15:0] mem_m [int];
  int mbl = 1, mcl = 2;
  logic [3:0] mopen = 4'b0;
  int mrow [4];
  logic [15:0] wd [8];
  logic [7:0] wl = 8'd0, wu = 8'd0;
  sdram_device_model_if bus();
  assign dq = tb_oe ? tb_dq : 16'hzzzz;
  always #5 iclk = ~iclk;
  sdram_device_model dut (
    .iclk(iclk), .ireset_n(ireset_n), .bus(bus), .DRAM_DQ(dq),
    .omode_set(omode_set), .ocmd_err(ocmd_err), .obank_open(obank_open), .orefresh_cnt(orefresh_cnt)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Array index from the burst rules: sequential order wrapping inside the BL-aligned block.
  function automatic int maddr(input int ba, input int row, input int col, input int i);
    int c = col % 64;
    return ba * 1024 + (row % 16) * 64 + (c / mbl) * mbl + (c + i) % mbl;
  endfunction
  task automatic tick();
    @(posedge iclk);
    #1;
    bus.DRAM_CS_N = 1'b1;
    {bus.DRAM_RAS_N, bus.DRAM_CAS_N, bus.DRAM_WE_N} = 3'b111;
  endtask
  task automatic pins(input logic [2:0] c, input int ba, input int a);
    bus.DRAM_CS_N = 1'b0;
    {bus.DRAM_RAS_N, bus.DRAM_CAS_N, bus.DRAM_WE_N} = c;
    bus.DRAM_BA = ba[1:0];
    bus.DRAM_ADDR = a[12:0];
  endtask
  task automatic issue(input logic [2:0] c, input int ba, input int a);
    pins(c, ba, a);
    tick();
  endtask
  task automatic do_act(input int ba, input int row);
    issue(ACT, ba, row);
    mopen[ba] = 1'b1;
    mrow[ba] = row;
  endtask
  task automatic do_pre_all();
    issue(PRE, 0, 1024);
    mopen = 4'b0;
  endtask
  task automatic do_lmr(input int a);
    issue(LMR, 0, a);
    mbl = 1 << (a % 8);
    mcl = (a / 16) % 8;
  endtask
  task automatic wr_burst(input int ba, input int col);
    int a;
    logic [15:0] old;
    for (int i = 0; i < mbl; i++) begin
      a = maddr(ba, mrow[ba], col, i);
      old = mem_m.exists(a) ? mem_m[a] : 16'h0000;
      mem_m[a] = {wu[i] ? old[15:8] : wd[i][15:8], wl[i] ? old[7:0] : wd[i][7:0]};
      if (i == 0) pins(WR, ba, col);
      tb_oe = !(wl[i] && wu[i]);
      tb_dq = wd[i];
      bus.DRAM_LDQM = wl[i];
      bus.DRAM_UDQM = wu[i];
      tick();
      if (!tb_oe) check("wr_released", dq, Z);
    end
    tb_oe = 1'b0;
    bus.DRAM_LDQM = 1'b0;
    bus.DRAM_UDQM = 1'b0;
  endtask
  // Word i is visible after edge T0+CL-1+i; bt>0 issues BURST TERMINATE at edge T0+bt.
  task automatic rd_check(input int ba, input int col, input bit ap, input int bt);
    int n, k;
    logic [15:0] w [8];
    n = (bt > 0 && bt < mbl) ? bt : mbl;
    for (int i = 0; i < n; i++) w[i] = mem_m[maddr(ba, mrow[ba], col, i)];
    issue(RD, ba, (ap ? 1024 : 0) + col);
    for (int j = 0; j < mcl + mbl; j++) begin
      k = j - mcl + 1;
      check("rd_dq", dq, (k >= 0 && k < n) ? w[k] : Z);
      if (bt > 0 && j + 1 == bt) pins(BT, ba, 0);
      tick();
    end
    if (ap) mopen[ba] = 1'b0;
  endtask
  initial begin
    bus.DRAM_CKE = 1'b1;
    bus.DRAM_CLK = 1'b0;
    bus.DRAM_LDQM = 1'b0;
    bus.DRAM_UDQM = 1'b0;
    bus.DRAM_BA = 2'd0;
    bus.DRAM_ADDR = 13'd0;
    repeat (3) tick();
    check("rst_mode", omode_set, 0);
    check("rst_err", ocmd_err, 0);
    check("rst_open", obank_open, 0);
    check("rst_ref", orefresh_cnt, 0);
    check("rst_dq", dq, Z);
    ireset_n = 1'b1;
    tick();
    issue(ACT, 0, 0);
    check("act_nomode_err", ocmd_err, 1);
    check("act_nomode_open", obank_open, 0);
    do_lmr('h033);
    check("lmr_set", omode_set, 1);
    check("lmr_noerr", ocmd_err, 0);
    issue(RD, 1, 8);
    check("rd_closed_err", ocmd_err, 1);
    tick();
    check("err_pulse", ocmd_err, 0);
    do_act(1, 5);
    check("act_open", obank_open, mopen);
    for (int i = 0; i < 8; i++) wd[i] = 16'h1000 + 16'(i);
    wr_burst(1, 8);
    rd_check(1, 8, 0, 0);
    for (int i = 0; i < 8; i++) wd[i] = 16'h2000 + 16'(i);
    wu = 8'b0000_0100;
    wr_burst(1, 'h0D);
    wu = 8'd0;
    rd_check(1, 8, 0, 0);
    issue(LMR, 0, 'h022);
    check("lmr_open_err", ocmd_err, 1);
    do_pre_all();
    check("pre_all", obank_open, 0);
    issue(LMR, 0, 'h034);
    check("lmr_bl_err", ocmd_err, 1);
    issue(LMR, 0, 'h043);
    check("lmr_cl_err", ocmd_err, 1);
    do_lmr('h022);
    check("lmr2_noerr", ocmd_err, 0);
    do_act(2, 'h13);
    for (int i = 0; i < 8; i++) wd[i] = 16'($urandom_range(0, 'hFFFE));
    wr_burst(2, 'h21);
    rd_check(2, 'h20, 1, 0);
    check("ap_closed", obank_open, mopen);
    issue(RD, 2, 'h20);
    check("rd_after_ap_err", ocmd_err, 1);
    do_lmr('h033);
    do_act(0, 7);
    for (int i = 0; i < 8; i++) wd[i] = 16'($urandom_range(0, 'hFFFE));
    wr_burst(0, 0);
    issue(RD, 0, 0);
    check("trunc_t0", dq, Z);
    tick();
    check("trunc_t1", dq, Z);
    tick();
    check("trunc_word0", dq, mem_m[maddr(0, 7, 0, 0)]);
    for (int i = 0; i < 8; i++) wd[i] = 16'($urandom_range(0, 'hFFFE));
    wl = 8'b1;
    wu = 8'b1;
    wr_burst(0, 0);
    wl = 8'd0;
    wu = 8'd0;
    rd_check(0, 0, 0, 0);
    rd_check(0, 3, 0, 2);
    for (int it = 0; it < 24; it++) begin
      int ba, row, col, col2;
      bit ap;
      do_pre_all();
      do_lmr(int'($urandom_range(2, 3)) * 16 + int'($urandom_range(0, 3)));
      ba = $urandom_range(0, 3);
      row = $urandom_range(0, 8191);
      col = $urandom_range(0, 63);
      do_act(ba, row);
      for (int i = 0; i < 8; i++) wd[i] = 16'($urandom_range(0, 'hFFFE));
      wr_burst(ba, col);
      for (int i = 0; i < 8; i++) wd[i] = 16'($urandom_range(0, 'hFFFE));
      wl = 8'($urandom);
      wu = 8'($urandom);
      col2 = (col % 64 / mbl) * mbl + int'($urandom_range(0, mbl - 1)) + 64 * int'($urandom_range(0, 3));
      wr_burst(ba, col2);
      wl = 8'd0;
      wu = 8'd0;
      ap = 1'($urandom);
      rd_check(ba, (col / mbl) * mbl + int'($urandom_range(0, mbl - 1)), ap, 0);
      check("rnd_open", obank_open, mopen);
    end
    do_pre_all();
    do_lmr('h033);
    repeat (5) issue(REF, 0, 0);
    check("ref_cnt", orefresh_cnt, 5);
    check("ref_noerr", ocmd_err, 0);
    do_act(0, 7);
    issue(REF, 0, 0);
    check("ref_open_err", ocmd_err, 1);
    check("ref_open_cnt", orefresh_cnt, 5);
    bus.DRAM_CKE = 1'b0;
    pins(ACT, 3, 1);
    tick();
    bus.DRAM_CKE = 1'b1;
    check("cke_ignored", obank_open, mopen);
    check("cke_noerr", ocmd_err, 0);
    issue(RD, 0, 0);
    tick();
    tick();
    check("rst_rd_word0", dq, mem_m[maddr(0, 7, 0, 0)]);
    ireset_n = 1'b0;
    #1;
    check("rst_mid_dq", dq, Z);
    check("rst_mid_open", obank_open, 0);
    check("rst_mid_mode", omode_set, 0);
    tick();
    ireset_n = 1'b1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
